// File: rtl/tl_pkg.sv
// Shared TileLink-UL A-channel definitions: opcodes, FSM states and the
// layout of the request record handed to the D-channel responder.
package tl_pkg;

   // TileLink-UL opcodes accepted by the slave
   localparam logic [2:0] PUT_FULL    = 3'd0;
   localparam logic [2:0] PUT_PARTIAL = 3'd1;
   localparam logic [2:0] GET         = 3'd4;

   // Front-end states: waiting for a header, mid-burst, or holding a finished
   // message until the request FIFO has room
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // Request record is {err, opcode, size, source, address}, address in the LSBs
   function automatic int rq_w(input int size_w, input int src_w, input int addr_w);
      return 4 + size_w + src_w + addr_w;
   endfunction

   function automatic int rq_addr_lsb();
      return 0;
   endfunction

   function automatic int rq_src_lsb(input int addr_w);
      return addr_w;
   endfunction

   function automatic int rq_size_lsb(input int src_w, input int addr_w);
      return addr_w + src_w;
   endfunction

   function automatic int rq_op_lsb(input int size_w, input int src_w, input int addr_w);
      return addr_w + src_w + size_w;
   endfunction

   function automatic int rq_err_bit(input int size_w, input int src_w, input int addr_w);
      return addr_w + src_w + size_w + 3;
   endfunction

   // Opcode classification helpers
   function automatic logic is_legal_opcode(input logic [2:0] op);
      return (op == PUT_FULL) || (op == PUT_PARTIAL) || (op == GET);
   endfunction

   function automatic logic is_put_opcode(input logic [2:0] op);
      return (op == PUT_FULL) || (op == PUT_PARTIAL);
   endfunction

endpackage

// File: rtl/tl_beat_counter.sv
// Beat bookkeeping for one A-channel message: derives the beat count from the
// header size, counts accepted beats and flags the final one.
module tl_beat_counter
   import tl_pkg::*;
#(
   parameter int SIZE_W = 3,
   parameter int LDB    = 3,
   parameter int NB_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [SIZE_W-1:0] size,
   input  logic              single,
   input  logic              first,
   input  logic              step,
   output logic [NB_W-1:0]   beat_cnt,
   output logic              last
);

   localparam logic [SIZE_W:0] LDB_EXT = (SIZE_W + 1)'(LDB);

   logic [SIZE_W:0] size_ext;
   logic [SIZE_W:0] shamt;
   logic [NB_W-1:0] nb_calc;
   logic [NB_W-1:0] nb_q;

   // Beat count of the header on the bus; Gets and illegal requests are one beat
   always_comb begin
      size_ext = {1'b0, size};
      shamt    = '0;
      nb_calc  = NB_W'(1);
      if (!single && (size_ext > LDB_EXT)) begin
         shamt   = size_ext - LDB_EXT;
         nb_calc = NB_W'(1) << shamt;
      end
   end

   // Final beat: judged from the live header on the first beat, else from the latched count
   always_comb begin
      if (first) begin
         last = (nb_calc == NB_W'(1));
      end else begin
         last = (beat_cnt == (nb_q - NB_W'(1)));
      end
   end

   // Latch the beat count on the first beat and advance or clear on every accepted beat
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt <= '0;
         nb_q     <= '0;
      end else if (step) begin
         if (first) begin
            nb_q <= nb_calc;
         end
         if (last) begin
            beat_cnt <= '0;
         end else begin
            beat_cnt <= beat_cnt + NB_W'(1);
         end
      end
   end

endmodule

// File: rtl/tl_a_slave_v2.sv
// TileLink-UL A-channel slave front end: accepts PutFullData, PutPartialData
// and Get, turns Put bursts into per-beat memory writes and pushes one request
// record per message to the D-channel responder's FIFO.
module tl_a_slave_v2
   import tl_pkg::*;
#(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 32,
   parameter int SIZE_W   = 3,
   parameter int SRC_W    = 4,
   parameter int MAX_SIZE = 6,
   localparam int DB      = DATA_W / 8,
   localparam int LDB     = $clog2(DB),
   localparam int RQ_W    = rq_w(SIZE_W, SRC_W, ADDR_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [2:0]        a_opcode,
   input  logic [SIZE_W-1:0] a_size,
   input  logic [SRC_W-1:0]  a_source,
   input  logic [ADDR_W-1:0] a_address,
   input  logic [DB-1:0]     a_mask,
   input  logic [DATA_W-1:0] a_data,
   output logic              o_wen,
   output logic [ADDR_W-1:0] o_waddr,
   output logic [DB-1:0]     o_wmask,
   output logic [DATA_W-1:0] o_wdata,
   input  logic              i_wr_full,
   output logic [RQ_W-1:0]   o_req,
   output logic              o_push_req,
   input  logic              i_req_full
);

   localparam int NB_W = (MAX_SIZE > LDB) ? (MAX_SIZE - LDB + 1) : 1;
   localparam logic [SIZE_W:0] MAX_EXT = (SIZE_W + 1)'(MAX_SIZE);

   localparam int RQ_ADDR = rq_addr_lsb();
   localparam int RQ_SRC  = rq_src_lsb(ADDR_W);
   localparam int RQ_SIZE = rq_size_lsb(SRC_W, ADDR_W);
   localparam int RQ_OP   = rq_op_lsb(SIZE_W, SRC_W, ADDR_W);
   localparam int RQ_ERR  = rq_err_bit(SIZE_W, SRC_W, ADDR_W);

   state_t state_q;
   state_t state_d;

   logic [2:0]        op_q;
   logic [SIZE_W-1:0] size_q;
   logic [SRC_W-1:0]  src_q;
   logic [ADDR_W-1:0] addr_q;
   logic              err_q;

   logic              in_legal;
   logic              in_put;
   logic              accept;
   logic              first;
   logic              last;
   logic [NB_W-1:0]   beat_cnt;
   logic              push_d;

   logic [2:0]        hdr_op;
   logic [SIZE_W-1:0] hdr_size;
   logic [SRC_W-1:0]  hdr_src;
   logic [ADDR_W-1:0] hdr_addr;
   logic              hdr_err;
   logic [RQ_W-1:0]   rec_d;

   // Classify the header currently on the bus
   always_comb begin
      in_legal = ({1'b0, a_size} <= MAX_EXT) && is_legal_opcode(a_opcode);
      in_put   = in_legal && is_put_opcode(a_opcode);
   end

   // Ready depends on which sink the beat is headed for; nothing is taken in HOLD or reset
   always_comb begin
      a_ready = 1'b0;
      if (!rst) begin
         case (state_q)
            IDLE:    a_ready = in_put ? !i_wr_full : !i_req_full;
            BURST:   a_ready = !i_wr_full;
            default: a_ready = 1'b0;
         endcase
      end
   end

   assign accept = a_valid && a_ready;
   assign first  = accept && (state_q == IDLE);

   tl_beat_counter #(
      .SIZE_W (SIZE_W),
      .LDB    (LDB),
      .NB_W   (NB_W)
   ) u_beat_counter (
      .clk      (clk),
      .rst      (rst),
      .size     (a_size),
      .single   (!in_put),
      .first    (first),
      .step     (accept),
      .beat_cnt (beat_cnt),
      .last     (last)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and the decision to push a record on the coming edge
   always_comb begin
      state_d = state_q;
      push_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (!last) begin
                  state_d = BURST;
               end else if (i_req_full) begin
                  state_d = HOLD;
               end else begin
                  state_d = IDLE;
                  push_d  = 1'b1;
               end
            end
         end
         BURST: begin
            if (accept && last) begin
               if (i_req_full) begin
                  state_d = HOLD;
               end else begin
                  state_d = IDLE;
                  push_d  = 1'b1;
               end
            end
         end
         HOLD: begin
            if (!i_req_full) begin
               state_d = IDLE;
               push_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Memory write path, live in the accept cycle and zeroed otherwise
   always_comb begin
      o_wen   = 1'b0;
      o_waddr = '0;
      o_wmask = '0;
      o_wdata = '0;
      if (accept && ((state_q == BURST) || ((state_q == IDLE) && in_put))) begin
         o_wen   = 1'b1;
         o_wdata = a_data;
         if (state_q == IDLE) begin
            o_waddr = a_address;
            o_wmask = (a_opcode == PUT_PARTIAL) ? a_mask : '1;
         end else begin
            o_waddr = addr_q + (ADDR_W'(beat_cnt) << LDB);
            o_wmask = (op_q == PUT_PARTIAL) ? a_mask : '1;
         end
      end
   end

   // Header of the message being completed: live on a first-beat completion, latched otherwise
   always_comb begin
      if (state_q == IDLE) begin
         hdr_op   = a_opcode;
         hdr_size = a_size;
         hdr_src  = a_source;
         hdr_addr = a_address;
         hdr_err  = !in_legal;
      end else begin
         hdr_op   = op_q;
         hdr_size = size_q;
         hdr_src  = src_q;
         hdr_addr = addr_q;
         hdr_err  = err_q;
      end
      rec_d                       = '0;
      rec_d[RQ_ERR]               = hdr_err;
      rec_d[RQ_OP +: 3]           = hdr_op;
      rec_d[RQ_SIZE +: SIZE_W]    = hdr_size;
      rec_d[RQ_SRC +: SRC_W]      = hdr_src;
      rec_d[RQ_ADDR +: ADDR_W]    = hdr_addr;
   end

   // Capture the header on the first beat; later beats reuse it
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q   <= '0;
         size_q <= '0;
         src_q  <= '0;
         addr_q <= '0;
         err_q  <= 1'b0;
      end else if (first) begin
         op_q   <= a_opcode;
         size_q <= a_size;
         src_q  <= a_source;
         addr_q <= a_address;
         err_q  <= !in_legal;
      end
   end

   // One-cycle registered push of the request record
   always_ff @(posedge clk) begin
      if (rst) begin
         o_push_req <= 1'b0;
         o_req      <= '0;
      end else begin
         o_push_req <= push_d;
         o_req      <= push_d ? rec_d : '0;
      end
   end

endmodule

// File: tb/tb_tl_a_slave_v2.sv
// Self-checking bench for tl_a_slave_v2: directed scenarios plus a randomized
// run scored against a message-level reference model.
module tb_tl_a_slave_v2;

   localparam int DATA_W   = 64;
   localparam int ADDR_W   = 32;
   localparam int SIZE_W   = 3;
   localparam int SRC_W    = 4;
   localparam int MAX_SIZE = 6;
   localparam int DB       = DATA_W / 8;
   localparam int RQ_W     = 4 + SIZE_W + SRC_W + ADDR_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              a_valid = 1'b0;
   logic              a_ready;
   logic [2:0]        a_opcode = '0;
   logic [SIZE_W-1:0] a_size = '0;
   logic [SRC_W-1:0]  a_source = '0;
   logic [ADDR_W-1:0] a_address = '0;
   logic [DB-1:0]     a_mask = '0;
   logic [DATA_W-1:0] a_data = '0;
   logic              o_wen;
   logic [ADDR_W-1:0] o_waddr;
   logic [DB-1:0]     o_wmask;
   logic [DATA_W-1:0] o_wdata;
   logic              i_wr_full = 1'b0;
   logic [RQ_W-1:0]   o_req;
   logic              o_push_req;
   logic              i_req_full = 1'b0;

   int n_cmp = 0;
   int n_err = 0;
   int idle_leak = 0;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DB-1:0]     mask;
      logic [DATA_W-1:0] data;
   } wr_t;

   wr_t             wr_obs[$];
   wr_t             wr_exp[$];
   logic [RQ_W-1:0] rq_obs[$];
   logic [RQ_W-1:0] rq_exp[$];

   logic [DATA_W-1:0] beat_data[16];
   logic [DB-1:0]     beat_mask[16];

   always #5 clk = ~clk;

   tl_a_slave_v2 #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .SIZE_W   (SIZE_W),
      .SRC_W    (SRC_W),
      .MAX_SIZE (MAX_SIZE)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .a_valid    (a_valid),
      .a_ready    (a_ready),
      .a_opcode   (a_opcode),
      .a_size     (a_size),
      .a_source   (a_source),
      .a_address  (a_address),
      .a_mask     (a_mask),
      .a_data     (a_data),
      .o_wen      (o_wen),
      .o_waddr    (o_waddr),
      .o_wmask    (o_wmask),
      .o_wdata    (o_wdata),
      .i_wr_full  (i_wr_full),
      .o_req      (o_req),
      .o_push_req (o_push_req),
      .i_req_full (i_req_full)
   );

   // Mid-cycle monitor collecting writes and pushes
   always @(negedge clk) begin
      if (o_wen) begin
         wr_t w;
         w.addr = o_waddr;
         w.mask = o_wmask;
         w.data = o_wdata;
         wr_obs.push_back(w);
      end else if ((o_waddr != '0) || (o_wmask != '0) || (o_wdata != '0)) begin
         idle_leak++;
      end
      if (o_push_req) rq_obs.push_back(o_req);
   end

   // Beats a message occupies on the A channel
   function automatic int beats_of(input logic [2:0] op, input logic [SIZE_W-1:0] size);
      int s;
      s = int'(size);
      if (s > MAX_SIZE) return 1;
      if ((op != 3'd0) && (op != 3'd1)) return 1;
      return (s > 3) ? (1 << (s - 3)) : 1;
   endfunction

   // Expected writes and record for one message
   function automatic void model_msg(input logic [2:0] op, input logic [SIZE_W-1:0] size,
                                     input logic [SRC_W-1:0] src, input logic [ADDR_W-1:0] addr);
      bit legal;
      int nb;
      wr_t w;
      legal = (int'(size) <= MAX_SIZE) && ((op == 3'd0) || (op == 3'd1) || (op == 3'd4));
      nb = beats_of(op, size);
      if (legal && (op != 3'd4)) begin
         for (int i = 0; i < nb; i++) begin
            w.addr = addr + ADDR_W'(i * DB);
            w.mask = (op == 3'd1) ? beat_mask[i] : '1;
            w.data = beat_data[i];
            wr_exp.push_back(w);
         end
      end
      rq_exp.push_back({~legal, op, size, src, addr});
   endfunction

   function automatic void fill_beats();
      for (int i = 0; i < 16; i++) begin
         beat_data[i] = {$urandom, $urandom};
         beat_mask[i] = DB'($urandom);
      end
   endfunction

   function automatic void clear_queues();
      wr_obs.delete();
      wr_exp.delete();
      rq_obs.delete();
      rq_exp.delete();
   endfunction

   // Present one beat and wait (bounded) for its handshake; returns at posedge+1
   task automatic drive_beat(input logic [2:0] op, input logic [SIZE_W-1:0] size,
                             input logic [SRC_W-1:0] src, input logic [ADDR_W-1:0] addr,
                             input logic [DB-1:0] mask, input logic [DATA_W-1:0] data);
      int waited;
      waited = 0;
      a_valid   = 1'b1;
      a_opcode  = op;
      a_size    = size;
      a_source  = src;
      a_address = addr;
      a_mask    = mask;
      a_data    = data;
      @(negedge clk);
      while (!a_ready) begin
         waited++;
         if (waited > 200) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL handshake_timeout: a_ready=%b after %0d cycles, required 1", a_ready, waited);
            a_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      a_valid = 1'b0;
   endtask

   // Send a whole message; later beats carry random (ignored) header fields
   task automatic send_msg(input logic [2:0] op, input logic [SIZE_W-1:0] size,
                           input logic [SRC_W-1:0] src, input logic [ADDR_W-1:0] addr,
                           input int gap_pct);
      int nb;
      nb = beats_of(op, size);
      for (int i = 0; i < nb; i++) begin
         if ($urandom_range(0, 99) < gap_pct) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         if (i == 0) drive_beat(op, size, src, addr, beat_mask[0], beat_data[0]);
         else drive_beat(3'($urandom), SIZE_W'($urandom), SRC_W'($urandom), $urandom, beat_mask[i], beat_data[i]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (o_push_req !== 1'b0) begin n_err++; $display("[TB] FAIL reset_push: got %b want 0", o_push_req); end
      n_cmp++;
      if (o_req !== '0) begin n_err++; $display("[TB] FAIL reset_req: got %h want 0", o_req); end
      n_cmp++;
      if (o_wen !== 1'b0) begin n_err++; $display("[TB] FAIL reset_wen: got %b want 0", o_wen); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (a_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_idle_ready: got %b want 1", a_ready); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_put_full_burst();
      logic [SRC_W-1:0] src;
      time t0;
      src = 4'h5;
      fill_beats();
      clear_queues();
      model_msg(3'd0, 3'd6, src, 32'h100);
      t0 = $time;
      send_msg(3'd0, 3'd6, src, 32'h100, 0);
      n_cmp++;
      if (($time - t0) !== 80) begin n_err++; $display("[TB] FAIL burst_back_to_back: took %0t want 80", $time - t0); end
      n_cmp++;
      if (o_push_req !== 1'b1) begin n_err++; $display("[TB] FAIL burst_push_timing: got %b want 1", o_push_req); end
      @(posedge clk);
      #1;
      n_cmp++;
      if (o_push_req !== 1'b0) begin n_err++; $display("[TB] FAIL burst_push_width: got %b want 0", o_push_req); end
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (wr_obs.size() != 8) begin n_err++; $display("[TB] FAIL burst_write_count: got %0d want 8", wr_obs.size()); end
      for (int i = 0; (i < wr_obs.size()) && (i < wr_exp.size()); i++) begin
         n_cmp++;
         if (wr_obs[i] !== wr_exp[i]) begin
            n_err++;
            $display("[TB] FAIL burst_write[%0d]: got %h want %h", i, wr_obs[i], wr_exp[i]);
         end
      end
      n_cmp++;
      if (rq_obs.size() != 1) begin n_err++; $display("[TB] FAIL burst_push_count: got %0d want 1", rq_obs.size()); end
      else begin
         n_cmp++;
         if (rq_obs[0] !== {1'b0, 3'd0, 3'd6, src, 32'h100}) begin
            n_err++;
            $display("[TB] FAIL burst_record: got %h want %h", rq_obs[0], {1'b0, 3'd0, 3'd6, src, 32'h100});
         end
      end
   endtask

   task automatic test_put_partial();
      logic [SRC_W-1:0] src;
      src = 4'hA;
      fill_beats();
      beat_mask[0] = 8'h0F;
      clear_queues();
      send_msg(3'd1, 3'd3, src, 32'h0000_0230, 0);
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (wr_obs.size() != 1) begin n_err++; $display("[TB] FAIL partial_write_count: got %0d want 1", wr_obs.size()); end
      else begin
         n_cmp++;
         if (wr_obs[0] !== {32'h0000_0230, 8'h0F, beat_data[0]}) begin
            n_err++;
            $display("[TB] FAIL partial_write: got %h want %h", wr_obs[0], {32'h0000_0230, 8'h0F, beat_data[0]});
         end
      end
      n_cmp++;
      if ((rq_obs.size() != 1) || (rq_obs[0] !== {1'b0, 3'd1, 3'd3, src, 32'h0000_0230})) begin
         n_err++;
         $display("[TB] FAIL partial_record: got %0d records, first %h", rq_obs.size(), (rq_obs.size() > 0) ? rq_obs[0] : '0);
      end
   endtask

   task automatic test_get_full();
      clear_queues();
      i_req_full = 1'b1;
      a_valid    = 1'b1;
      a_opcode   = 3'd4;
      a_size     = 3'd6;
      a_source   = 4'h9;
      a_address  = 32'h0000_2000;
      a_mask     = DB'($urandom);
      a_data     = {$urandom, $urandom};
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_cmp++;
         if (a_ready !== 1'b0) begin n_err++; $display("[TB] FAIL get_blocked_ready[%0d]: got %b want 0", k, a_ready); end
      end
      @(posedge clk);
      #1;
      i_req_full = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (a_ready !== 1'b1) begin n_err++; $display("[TB] FAIL get_ready: got %b want 1", a_ready); end
      @(posedge clk);
      #1;
      a_valid = 1'b0;
      n_cmp++;
      if (o_push_req !== 1'b1) begin n_err++; $display("[TB] FAIL get_push: got %b want 1", o_push_req); end
      n_cmp++;
      if (o_req !== {1'b0, 3'd4, 3'd6, 4'h9, 32'h0000_2000}) begin
         n_err++;
         $display("[TB] FAIL get_record: got %h want %h", o_req, {1'b0, 3'd4, 3'd6, 4'h9, 32'h0000_2000});
      end
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ((rq_obs.size() != 1) || (wr_obs.size() != 0)) begin
         n_err++;
         $display("[TB] FAIL get_counts: got %0d records %0d writes, want 1 and 0", rq_obs.size(), wr_obs.size());
      end
   endtask

   task automatic test_hold();
      logic [SRC_W-1:0] src;
      src = 4'h7;
      fill_beats();
      clear_queues();
      drive_beat(3'd0, 3'd4, src, 32'h0000_0800, beat_mask[0], beat_data[0]);
      i_req_full = 1'b1;
      drive_beat(3'd0, 3'd4, src, 32'h0000_0800, beat_mask[1], beat_data[1]);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_cmp++;
         if ((a_ready !== 1'b0) || (o_push_req !== 1'b0)) begin
            n_err++;
            $display("[TB] FAIL hold_cycle[%0d]: a_ready=%b push=%b, want 0 and 0", k, a_ready, o_push_req);
         end
      end
      @(posedge clk);
      #1;
      i_req_full = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (o_push_req !== 1'b0) begin n_err++; $display("[TB] FAIL hold_early_push: got %b want 0", o_push_req); end
      @(negedge clk);
      n_cmp++;
      if (o_push_req !== 1'b1) begin n_err++; $display("[TB] FAIL hold_release_push: got %b want 1", o_push_req); end
      @(negedge clk);
      n_cmp++;
      if (o_push_req !== 1'b0) begin n_err++; $display("[TB] FAIL hold_push_width: got %b want 0", o_push_req); end
      @(posedge clk);
      #1;
      n_cmp++;
      if ((wr_obs.size() != 2) || (wr_obs[1].addr !== 32'h0000_0808)) begin
         n_err++;
         $display("[TB] FAIL hold_writes: got %0d writes, want 2 ending at 00000808", wr_obs.size());
      end
      n_cmp++;
      if ((rq_obs.size() != 1) || (rq_obs[0] !== {1'b0, 3'd0, 3'd4, src, 32'h0000_0800})) begin
         n_err++;
         $display("[TB] FAIL hold_record: got %0d records, first %h", rq_obs.size(), (rq_obs.size() > 0) ? rq_obs[0] : '0);
      end
   endtask

   task automatic test_illegal();
      fill_beats();
      clear_queues();
      send_msg(3'd2, 3'd3, 4'h3, 32'h0000_0500, 0);
      send_msg(3'd0, 3'd7, 4'h4, 32'h0000_0600, 0);
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (wr_obs.size() != 0) begin n_err++; $display("[TB] FAIL illegal_writes: got %0d want 0", wr_obs.size()); end
      n_cmp++;
      if (rq_obs.size() != 2) begin n_err++; $display("[TB] FAIL illegal_push_count: got %0d want 2", rq_obs.size()); end
      else begin
         n_cmp++;
         if (rq_obs[0] !== {1'b1, 3'd2, 3'd3, 4'h3, 32'h0000_0500}) begin
            n_err++;
            $display("[TB] FAIL illegal_opcode_record: got %h want %h", rq_obs[0], {1'b1, 3'd2, 3'd3, 4'h3, 32'h0000_0500});
         end
         n_cmp++;
         if (rq_obs[1] !== {1'b1, 3'd0, 3'd7, 4'h4, 32'h0000_0600}) begin
            n_err++;
            $display("[TB] FAIL illegal_size_record: got %h want %h", rq_obs[1], {1'b1, 3'd0, 3'd7, 4'h4, 32'h0000_0600});
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      fill_beats();
      clear_queues();
      drive_beat(3'd0, 3'd6, 4'h2, 32'h0000_0700, beat_mask[0], beat_data[0]);
      drive_beat(3'd0, 3'd6, 4'h2, 32'h0000_0700, beat_mask[1], beat_data[1]);
      drive_beat(3'd0, 3'd6, 4'h2, 32'h0000_0700, beat_mask[2], beat_data[2]);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (rq_obs.size() != 0) begin n_err++; $display("[TB] FAIL reset_burst_push: got %0d records want 0", rq_obs.size()); end
      fill_beats();
      clear_queues();
      model_msg(3'd0, 3'd4, 4'hC, 32'h0000_0400);
      send_msg(3'd0, 3'd4, 4'hC, 32'h0000_0400, 0);
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (wr_obs.size() != 2) begin n_err++; $display("[TB] FAIL after_reset_count: got %0d want 2", wr_obs.size()); end
      for (int i = 0; (i < wr_obs.size()) && (i < wr_exp.size()); i++) begin
         n_cmp++;
         if (wr_obs[i] !== wr_exp[i]) begin
            n_err++;
            $display("[TB] FAIL after_reset_write[%0d]: got %h want %h", i, wr_obs[i], wr_exp[i]);
         end
      end
      n_cmp++;
      if ((rq_obs.size() != 1) || (rq_obs[0] !== rq_exp[0])) begin
         n_err++;
         $display("[TB] FAIL after_reset_record: got %0d records, first %h want %h", rq_obs.size(), (rq_obs.size() > 0) ? rq_obs[0] : '0, rq_exp[0]);
      end
   endtask

   task automatic test_random();
      bit stop_tog;
      stop_tog = 1'b0;
      clear_queues();
      idle_leak = 0;
      fork
         begin
            for (int m = 0; m < 60; m++) begin
               logic [2:0]        op;
               logic [SIZE_W-1:0] size;
               logic [SRC_W-1:0]  src;
               logic [ADDR_W-1:0] addr;
               int                r;
               r = $urandom_range(0, 9);
               if (r < 4) op = 3'd0;
               else if (r < 7) op = 3'd1;
               else if (r < 9) op = 3'd4;
               else begin
                  op = 3'($urandom_range(2, 7));
                  if (op == 3'd4) op = 3'd3;
               end
               size = SIZE_W'($urandom_range(0, 7));
               src  = SRC_W'($urandom);
               addr = $urandom;
               fill_beats();
               model_msg(op, size, src, addr);
               send_msg(op, size, src, addr, 30);
            end
            stop_tog = 1'b1;
         end
         begin
            while (!stop_tog) begin
               @(posedge clk);
               #1;
               i_wr_full  = ($urandom_range(0, 3) == 0);
               i_req_full = ($urandom_range(0, 3) == 0);
            end
         end
      join
      i_wr_full  = 1'b0;
      i_req_full = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      n_cmp++;
      if (wr_obs.size() != wr_exp.size()) begin
         n_err++;
         $display("[TB] FAIL random_write_count: got %0d want %0d", wr_obs.size(), wr_exp.size());
      end
      for (int i = 0; (i < wr_obs.size()) && (i < wr_exp.size()); i++) begin
         n_cmp++;
         if (wr_obs[i] !== wr_exp[i]) begin
            n_err++;
            $display("[TB] FAIL random_write[%0d]: got %h want %h", i, wr_obs[i], wr_exp[i]);
         end
      end
      n_cmp++;
      if (rq_obs.size() != rq_exp.size()) begin
         n_err++;
         $display("[TB] FAIL random_push_count: got %0d want %0d", rq_obs.size(), rq_exp.size());
      end
      for (int i = 0; (i < rq_obs.size()) && (i < rq_exp.size()); i++) begin
         n_cmp++;
         if (rq_obs[i] !== rq_exp[i]) begin
            n_err++;
            $display("[TB] FAIL random_record[%0d]: got %h want %h", i, rq_obs[i], rq_exp[i]);
         end
      end
      n_cmp++;
      if (idle_leak != 0) begin
         n_err++;
         $display("[TB] FAIL idle_write_outputs: got %0d nonzero idle cycles want 0", idle_leak);
      end
   endtask

   initial begin
      test_reset();
      test_put_full_burst();
      test_put_partial();
      test_get_full();
      test_hold();
      test_illegal();
      test_reset_mid_burst();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
